// File: rtl/apb_master_if.sv
// APB bus between apb_master and the slave side. The master drives
// address, control and write data; the slave returns read data and ready.
interface apb_master_if #(
    parameter int DATA = 32,
    parameter int ADDR = 32
);
    logic [ADDR-1:0] paddr;
    logic            pwrite;
    logic [DATA-1:0] pwdata;
    logic            psel;
    logic            penable;
    logic [DATA-1:0] prdata;
    logic            pready;

    modport master (
        output paddr, pwrite, pwdata, psel, penable,
        input  prdata, pready
    );

    modport slave (
        input  paddr, pwrite, pwdata, psel, penable,
        output prdata, pready
    );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB requester: valid/ready command in, SETUP/ACCESS on
// the bus, one-cycle response strobe out (read data or timeout).
module apb_master #(
    parameter int DATA    = 32,
    parameter int ADDR    = 32,
    parameter int TIMEOUT = 16,
    parameter int TO_W    = 8
) (
    input  logic            pclk,
    input  logic            presetn,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_write,
    input  logic [ADDR-1:0] cmd_addr,
    input  logic [DATA-1:0] cmd_wdata,
    output logic            rsp_valid,
    output logic [DATA-1:0] rsp_rdata,
    output logic            rsp_timeout,
    apb_master_if.master    apb
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    localparam logic [TO_W-1:0] TO_LAST = (TIMEOUT == 0) ? '0 : TO_W'(TIMEOUT - 1);

    state_t          state, state_nxt;
    logic [TO_W-1:0] wait_cnt;
    logic            accept, done_ok, done_to, to_hit;
    logic [ADDR-1:0] paddr_q;
    logic            pwrite_q;
    logic [DATA-1:0] pwdata_q;
    logic            psel_q, penable_q;

    assign to_hit    = (TIMEOUT != 0) && (wait_cnt == TO_LAST);
    // Gated with presetn so nothing upstream sees ready while the block is held in reset.
    assign cmd_ready = presetn && (state == IDLE);

    assign apb.paddr   = paddr_q;
    assign apb.pwrite  = pwrite_q;
    assign apb.pwdata  = pwdata_q;
    assign apb.psel    = psel_q;
    assign apb.penable = penable_q;

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) state <= IDLE;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        done_ok   = 1'b0;
        done_to   = 1'b0;
        unique case (state)
            IDLE: begin
                if (cmd_valid) begin
                    accept    = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: state_nxt = ACCESS;
            ACCESS: begin
                // pready wins over an expiring counter on the same edge
                if (apb.pready) begin
                    done_ok   = 1'b1;
                    state_nxt = IDLE;
                end else if (to_hit) begin
                    done_to   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            paddr_q     <= '0;
            pwrite_q    <= 1'b0;
            pwdata_q    <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            rsp_valid   <= 1'b0;
            rsp_timeout <= 1'b0;
            rsp_rdata   <= '0;
            wait_cnt    <= '0;
        end else begin
            psel_q      <= (state_nxt != IDLE);
            penable_q   <= (state_nxt == ACCESS);
            rsp_valid   <= done_ok || done_to;
            rsp_timeout <= done_to;
            if (accept) begin
                paddr_q  <= cmd_addr;
                pwrite_q <= cmd_write;
                pwdata_q <= cmd_wdata;
                wait_cnt <= '0;
            end else if (state == ACCESS && !apb.pready) begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (done_ok && !pwrite_q) rsp_rdata <= apb.prdata;
        end
    end

endmodule
